lut_neuron_loader: RTL and testbench
====================================

Name: lut_neuron_loader

Overview:
- Runtime-programmable LogicNets neuron. It is the write side of the fixed neuron truth tables: the same 7-bit-in / 2-bit-out lookup, but the table is written at run time over a streamed load port.
- Used to retune readout neurons without re-synthesis.
- Sits between the host configuration stream and the layer datapath. Lookups are registered, 1-cycle latency.

Parameters:
- IN_W, 7, lookup address width; table depth = 2**IN_W.
- OUT_W, 2, output code width per entry.
- EPB, 4, entries per load beat; load beat width = EPB*OUT_W. 2**IN_W must be a multiple of EPB.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, asynchronous, active-high reset.
- load_start, input, 1, pulse: begin or restart a table load.
- load_data, input, EPB*OUT_W, EPB entries. Entry k sits in bits [k*OUT_W +: OUT_W] and goes to address base+k.
- load_valid, input, 1, load beat valid.
- load_ready, output, 1, load beat accepted when load_valid && load_ready.
- load_done, output, 1, one-cycle pulse after the last beat is written.
- table_valid, output, 1, high while a complete table is present.
- in_data, input, IN_W, lookup address (packed quantized activations).
- in_valid, input, 1, lookup request.
- out_data, output, OUT_W, registered lookup result.
- out_valid, output, 1, registered in_valid.

Behaviour:
- States: IDLE, LOAD, READY.
- Reset (async, any state, mid-load included):
  - State goes to IDLE.
  - load_ready=0, load_done=0, table_valid=0, out_valid=0, out_data=0, beat counter=0.
  - Table RAM contents are not reset.
- IDLE:
  - load_ready=0.
  - load_start moves to LOAD next cycle with counter=0.
- LOAD:
  - load_ready=1, table_valid=0.
  - Each accepted beat writes entries base..base+EPB-1, with base = counter*EPB. Counter then increments.
  - Beat accepted with counter = 2**IN_W/EPB - 1:
    - counter wraps to 0.
    - Next cycle: state READY, table_valid=1, load_done=1 for exactly one cycle.
  - load_start in LOAD: counter cleared to 0, state stays LOAD.
    - If load_start coincides with an accepted beat, the beat is dropped and load_start wins.
  - load_valid while load_ready=0 is ignored; there is no back-pressure storage.
- READY:
  - load_start drops table_valid the next cycle and enters LOAD. Old contents are overwritten progressively.
- Lookup path, independent of state, every cycle:
  - out_valid <= in_valid.
  - out_data <= table_valid ? table[in_data] : 0.
  - The read uses table contents before any same-cycle write (read-before-write).
  - Latency 1 cycle; one lookup per cycle.
- Writing and looking up the same address in the same cycle returns the old value. This only matters in LOAD, where out_data is 0 anyway.
- No X on out_data after reset, even with an unwritten table.

Optional Feature:
- Macro: LUT_LOAD_PARITY_EN.
- With the macro defined:
  - Extra input load_par (1 bit) carries even parity over load_data.
  - Extra output load_err (1 bit), sticky, reset 0, cleared by load_start.
  - An accepted beat with a parity mismatch is not written. load_err is set, the state returns to IDLE the next cycle, and table_valid stays 0 with no load_done.
- Without the macro: neither port exists and all beats are written unconditionally.

Test Plan:
- Reset then lookup in_data=7'h2A with in_valid=1 -> next cycle out_valid=1, out_data=2'b00, table_valid=0.
- load_start, then 32 beats with entry value = addr[1:0] (each beat 8'b11100100) -> load_done pulses once one cycle after beat 32, table_valid=1. Lookups of 0x05 and 0x7F return 2'b01 and 2'b11.
- Throttled load: load_valid deasserted every other cycle -> still exactly 32 accepted beats, with identical table and done timing relative to the last beat.
- Mid-load load_start after 10 beats, then 32 beats of 8'hFF -> load_done after the 32nd new beat, and every lookup returns 2'b11.
- Reset asserted asynchronously after 20 beats -> outputs 0 immediately, table_valid=0, load_ready=0. A fresh full load then completes normally.
- (LUT_LOAD_PARITY_EN) Beat 3 sent with wrong load_par -> load_err=1, state IDLE, table_valid=0, no load_done. A following load_start clears load_err.

Source files
------------

// File: rtl/lut_neuron_loader.sv
// rtl/lut_neuron_loader.sv - runtime-loadable LUT neuron: streamed table load plus 1-cycle registered lookup
// Optional macro LUT_LOAD_PARITY_EN adds load_par/load_err per-beat even-parity checking.
module lut_neuron_loader #(
   parameter int IN_W  = 7,
   parameter int OUT_W = 2,
   parameter int EPB   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_start,
   input  logic [EPB*OUT_W-1:0] load_data,
   input  logic                 load_valid,
   output logic                 load_ready,
   output logic                 load_done,
   output logic                 table_valid,
`ifdef LUT_LOAD_PARITY_EN
   input  logic                 load_par,
   output logic                 load_err,
`endif
   input  logic [IN_W-1:0]      in_data,
   input  logic                 in_valid,
   output logic [OUT_W-1:0]     out_data,
   output logic                 out_valid
);
   localparam int DEPTH = 2**IN_W;
   localparam int BEATS = DEPTH / EPB;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [OUT_W-1:0] mem [DEPTH];
   logic             accept;
   logic             par_ok;
   logic             wr_en;
   logic             last;

   // A restart wins over a beat presented in the same cycle.
   assign accept = load_valid && (state == LOAD) && !load_start;
`ifdef LUT_LOAD_PARITY_EN
   assign par_ok = ((^load_data) == load_par);
`else
   assign par_ok = 1'b1;
`endif
   assign wr_en  = accept && par_ok;
   assign last   = (cnt == CW'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < EPB; k++)
            mem[IN_W'(int'(cnt) * EPB + k)] <= load_data[k*OUT_W +: OUT_W];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         load_ready  <= 1'b0;
         load_done   <= 1'b0;
         table_valid <= 1'b0;
`ifdef LUT_LOAD_PARITY_EN
         load_err    <= 1'b0;
`endif
      end else begin
         load_done <= 1'b0;
         if (load_start) begin
            state       <= LOAD;
            cnt         <= '0;
            load_ready  <= 1'b1;
            table_valid <= 1'b0;
`ifdef LUT_LOAD_PARITY_EN
            load_err    <= 1'b0;
         end else if (accept && !par_ok) begin
            state      <= IDLE;
            cnt        <= '0;
            load_ready <= 1'b0;
            load_err   <= 1'b1;
`endif
         end else if (accept) begin
            if (last) begin
               state       <= READY;
               cnt         <= '0;
               load_ready  <= 1'b0;
               table_valid <= 1'b1;
               load_done   <= 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   // Gating with table_valid keeps out_data defined even before any table is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= in_valid;
         out_data  <= table_valid ? mem[in_data] : '0;
      end
   end
endmodule

// File: tb/tb_lut_neuron_loader.sv
// tb/tb_lut_neuron_loader.sv - randomized bench for lut_neuron_loader with an in-bench reference model
module tb_lut_neuron_loader;
   localparam int IN_W  = 7;
   localparam int OUT_W = 2;
   localparam int EPB   = 4;
   localparam int DEPTH = 128;
   localparam int BEATS = 32;
   localparam int BW    = EPB * OUT_W;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            load_start = 1'b0;
   logic            load_valid = 1'b0;
   logic            in_valid = 1'b0;
   logic [BW-1:0]   load_data = '0;
   logic [IN_W-1:0] in_data = '0;
   logic            load_ready, load_done, table_valid, out_valid;
   logic [OUT_W-1:0] out_data;
`ifdef LUT_LOAD_PARITY_EN
   logic load_par = 1'b0;
   logic load_err;
   bit   bad_par = 1'b0;
   bit   e_err = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int acc_cnt = 0;

   always #5 clk = ~clk;

   lut_neuron_loader #(.IN_W(IN_W), .OUT_W(OUT_W), .EPB(EPB)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .load_data(load_data),
      .load_valid(load_valid), .load_ready(load_ready), .load_done(load_done),
      .table_valid(table_valid),
`ifdef LUT_LOAD_PARITY_EN
      .load_par(load_par), .load_err(load_err),
`endif
      .in_data(in_data), .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid)
   );

   // Reference: table as a plain array, load progress as a beat count.
   logic [OUT_W-1:0] ref_mem [DEPTH];
   bit               e_ready = 0, e_done = 0, e_tv = 0, e_ov = 0;
   logic [OUT_W-1:0] e_od = '0;
   int               m_beats = 0;

   initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         e_ready = 0; e_done = 0; e_tv = 0; e_ov = 0; e_od = '0; m_beats = 0;
`ifdef LUT_LOAD_PARITY_EN
         e_err = 0;
`endif
      end else begin
         e_ov = in_valid;
         e_od = e_tv ? ref_mem[in_data] : '0;
         e_done = 0;
         if (load_start) begin
            e_ready = 1; e_tv = 0; m_beats = 0;
`ifdef LUT_LOAD_PARITY_EN
            e_err = 0;
`endif
         end else if (load_valid && e_ready) begin
            acc_cnt++;
`ifdef LUT_LOAD_PARITY_EN
            if (load_par != (^load_data)) begin
               e_err = 1; e_ready = 0; m_beats = 0;
            end else
`endif
            begin
               for (int k = 0; k < EPB; k++)
                  ref_mem[m_beats*EPB + k] = load_data[k*OUT_W +: OUT_W];
               m_beats++;
               if (m_beats == BEATS) begin
                  m_beats = 0; e_ready = 0; e_tv = 1; e_done = 1;
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("out_valid", out_valid, e_ov);
         chk("out_data", out_data, e_od);
         chk("table_valid", table_valid, e_tv);
         chk("load_ready", load_ready, e_ready);
         chk("load_done", load_done, e_done);
`ifdef LUT_LOAD_PARITY_EN
         chk("load_err", load_err, e_err);
`endif
         if (load_done) done_cnt++;
      end
   end

   task automatic do_start();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send(input logic [BW-1:0] d, input bit throttle);
      int guard = 0;
      if (throttle) begin
         load_valid = 1'b0;
         @(negedge clk);
      end
      load_data  = d;
      load_valid = 1'b1;
`ifdef LUT_LOAD_PARITY_EN
      load_par = (^d) ^ bad_par;
`endif
      while (!load_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!load_ready) chk("beat_accept_timeout", 0, 1);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic lookup(input logic [IN_W-1:0] a, input logic [OUT_W-1:0] exp, input string nm);
      in_data  = a;
      in_valid = 1'b1;
      @(negedge clk);
      chk(nm, out_data, exp);
      chk({nm, "_valid"}, out_valid, 1);
      in_valid = 1'b0;
   endtask

   task automatic check_done(input int d0, input string nm);
      chk({nm, "_done"}, load_done, 1);
      chk({nm, "_tv"}, table_valid, 1);
      @(negedge clk);
      chk({nm, "_done_once"}, done_cnt - d0, 1);
   endtask

   task automatic random_traffic(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid   = 1'($urandom);
         in_data    = IN_W'($urandom);
         load_valid = 1'($urandom);
         load_data  = BW'($urandom);
`ifdef LUT_LOAD_PARITY_EN
         load_par = ^load_data;
`endif
         @(negedge clk);
      end
      in_valid = 1'b0;
      load_valid = 1'b0;
   endtask

   initial begin
      int d0, a0;
      logic [IN_W-1:0] a;
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_load_ready", load_ready, 0);
      chk("rst_table_valid", table_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_load_done", load_done, 0);
      rst = 1'b0;
      lookup(7'h2A, 2'b00, "empty_lookup");
      chk("empty_tv", table_valid, 0);

      // Full load, entry value = addr[1:0].
      do_start();
      d0 = done_cnt;
      for (int b = 0; b < BEATS; b++) send(8'hE4, 0);
      check_done(d0, "load1");
      lookup(7'h05, 2'b01, "lk05");
      lookup(7'h7F, 2'b11, "lk7F");
      lookup(7'h2A, 2'b10, "lk2A");

      // Throttled load of the same pattern.
      do_start();
      d0 = done_cnt;
      a0 = acc_cnt;
      for (int b = 0; b < BEATS; b++) send(8'hE4, 1);
      chk("throttle_beats", acc_cnt - a0, BEATS);
      check_done(d0, "load2");
      for (int i = 0; i < 8; i++) begin
         a = IN_W'($urandom);
         lookup(a, a[1:0], "throttle_lk");
      end

      // Random table contents with random throttling, then random lookups.
      do_start();
      d0 = done_cnt;
      for (int b = 0; b < BEATS; b++) send(BW'($urandom), 1'($urandom));
      check_done(d0, "load3");
      random_traffic(300);

      // Restart after 10 beats; the beat coinciding with load_start must be dropped.
      do_start();
      for (int b = 0; b < 10; b++) send(BW'($urandom), 0);
      load_data = 8'h00;
      load_valid = 1'b1;
`ifdef LUT_LOAD_PARITY_EN
      load_par = 1'b0;
`endif
      do_start();
      load_valid = 1'b0;
      d0 = done_cnt;
      for (int b = 0; b < BEATS; b++) send(8'hFF, 0);
      check_done(d0, "restart");
      for (int i = 0; i < 12; i++) lookup(IN_W'($urandom), 2'b11, "ff_lk");

      // Asynchronous reset mid-load.
      do_start();
      in_valid = 1'b1;
      for (int b = 0; b < 20; b++) send(BW'($urandom), 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_load_ready", load_ready, 0);
      chk("arst_table_valid", table_valid, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, 0);
      @(negedge clk);
      rst = 1'b0;
      a0 = acc_cnt;
      load_valid = 1'b1;
      repeat (3) @(negedge clk);
      load_valid = 1'b0;
      in_valid = 1'b0;
      chk("idle_ignores_beats", acc_cnt - a0, 0);
      do_start();
      d0 = done_cnt;
      for (int b = 0; b < BEATS; b++) send(BW'($urandom), 1'($urandom));
      check_done(d0, "after_rst");
      random_traffic(200);

`ifdef LUT_LOAD_PARITY_EN
      do_start();
      d0 = done_cnt;
      send(BW'($urandom), 0);
      send(BW'($urandom), 0);
      bad_par = 1'b1;
      send(8'h5A, 0);
      bad_par = 1'b0;
      chk("par_err", load_err, 1);
      chk("par_ready", load_ready, 0);
      chk("par_tv", table_valid, 0);
      repeat (5) @(negedge clk);
      chk("par_no_done", done_cnt - d0, 0);
      do_start();
      chk("par_err_clr", load_err, 0);
      for (int b = 0; b < BEATS; b++) send(BW'($urandom), 0);
      check_done(d0, "par_reload");
      random_traffic(50);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
